// File: rtl/axi_spi_csr_pkg.sv
// axi_spi_csr_pkg: register offsets, field positions and AXI response codes for the SPI CSR block.
package axi_spi_csr_pkg;
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_TIMING = 3'd2;
    localparam logic [2:0] REG_TXDATA = 3'd3;
    localparam logic [2:0] REG_RXDATA = 3'd4;
    localparam int CTRL_START = 0;
    localparam int CTRL_MODE  = 1;
    localparam int CTRL_SPEED = 3;
    localparam int CTRL_WLEN  = 5;
    localparam int STAT_DONE  = 1;
    localparam int TIM_IFG    = 0;
    localparam int TIM_CS_SCK = 8;
    localparam int TIM_SCK_CS = 16;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axi_lite_wr_ctrl.sv
// axi_lite_wr_ctrl: one-entry AW and W buffers, commit strobe when both are held, and the B handshake.
module axi_lite_wr_ctrl #(
    parameter int ADDR_W = 5
) (
    input  logic              GCLK,
    input  logic              RST,
    input  logic              en,
    input  logic [ADDR_W-1:0] S_AXI_AWADDR,
    input  logic              S_AXI_AWVALID,
    output logic              S_AXI_AWREADY,
    input  logic [31:0]       S_AXI_WDATA,
    input  logic [3:0]        S_AXI_WSTRB,
    input  logic              S_AXI_WVALID,
    output logic              S_AXI_WREADY,
    output logic [1:0]        S_AXI_BRESP,
    output logic              S_AXI_BVALID,
    input  logic              S_AXI_BREADY,
    input  logic [1:0]        commit_resp,
    output logic              commit,
    output logic [ADDR_W-1:0] commit_addr,
    output logic [31:0]       commit_data,
    output logic [3:0]        commit_strb
);
    logic aw_full, w_full;
    assign S_AXI_AWREADY = en && !aw_full && !S_AXI_BVALID;
    assign S_AXI_WREADY  = en && !w_full && !S_AXI_BVALID;
    assign commit        = aw_full && w_full;
    always_ff @(posedge GCLK or negedge RST) begin
        if (!RST) begin
            aw_full      <= 1'b0;
            w_full       <= 1'b0;
            commit_addr  <= '0;
            commit_data  <= '0;
            commit_strb  <= '0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= 2'b00;
        end else begin
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                aw_full     <= 1'b1;
                commit_addr <= S_AXI_AWADDR;
            end
            if (S_AXI_WVALID && S_AXI_WREADY) begin
                w_full      <= 1'b1;
                commit_data <= S_AXI_WDATA;
                commit_strb <= S_AXI_WSTRB;
            end
            if (commit) begin
                aw_full      <= 1'b0;
                w_full       <= 1'b0;
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= commit_resp;
            end else if (S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/axi_spi_csr.sv
// axi_spi_csr: AXI4-Lite register file driving SPI_regs configuration/TX/start and capturing busy/MISO results.
module axi_spi_csr
    import axi_spi_csr_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              GCLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] S_AXI_AWADDR,
    input  logic              S_AXI_AWVALID,
    output logic              S_AXI_AWREADY,
    input  logic [31:0]       S_AXI_WDATA,
    input  logic [3:0]        S_AXI_WSTRB,
    input  logic              S_AXI_WVALID,
    output logic              S_AXI_WREADY,
    output logic [1:0]        S_AXI_BRESP,
    output logic              S_AXI_BVALID,
    input  logic              S_AXI_BREADY,
    input  logic [ADDR_W-1:0] S_AXI_ARADDR,
    input  logic              S_AXI_ARVALID,
    output logic              S_AXI_ARREADY,
    output logic [31:0]       S_AXI_RDATA,
    output logic [1:0]        S_AXI_RRESP,
    output logic              S_AXI_RVALID,
    input  logic              S_AXI_RREADY,
    output logic              start_out,
    output logic [1:0]        spi_mode_out,
    output logic [1:0]        sck_speed_out,
    output logic [1:0]        word_len_out,
    output logic [7:0]        IFG_out,
    output logic [7:0]        CS_SCK_out,
    output logic [7:0]        SCK_CS_out,
    output logic [31:0]       mosi_data_out,
    input  logic              busy_in,
    input  logic [31:0]       miso_data_in
);
    logic en, busy_q, pending, done, busy, rise, fall;
    logic wr_commit, wr_bad, wr_lock, wr_en, start, done_clr;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0] wr_data, rxdata, rd_val;
    logic [3:0] wr_strb;
    logic [1:0] wr_resp;
    logic [2:0] wi, ri;
    logic unused_addr_lsbs;
    axi_lite_wr_ctrl #(.ADDR_W(ADDR_W)) u_wr (
        .GCLK(GCLK), .RST(RST), .en(en),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .commit_resp(wr_resp), .commit(wr_commit),
        .commit_addr(wr_addr), .commit_data(wr_data), .commit_strb(wr_strb)
    );
    assign unused_addr_lsbs = ^{wr_addr[1:0], S_AXI_ARADDR[1:0]};
    assign busy     = pending | busy_in;
    assign rise     = busy_in & ~busy_q;
    assign fall     = busy_q & ~busy_in;
    assign wi       = wr_addr[4:2];
    assign ri       = S_AXI_ARADDR[4:2];
    assign wr_bad   = wi > REG_RXDATA;
    assign wr_lock  = busy && (wi == REG_CTRL || wi == REG_TIMING || wi == REG_TXDATA);
    assign wr_resp  = (wr_bad || wr_lock) ? RESP_SLVERR : RESP_OKAY;
    assign wr_en    = wr_commit && !wr_bad && !wr_lock;
    assign start    = wr_en && wi == REG_CTRL && wr_strb[0] && wr_data[CTRL_START];
    assign done_clr = wr_commit && wi == REG_STATUS && wr_strb[0] && wr_data[STAT_DONE];
    assign S_AXI_ARREADY = en && !S_AXI_RVALID;
    // Read data is sampled at the AR edge, so a same-edge write commit is not yet visible.
    always_comb begin
        rd_val = ri == REG_CTRL   ? {25'd0, word_len_out, sck_speed_out, spi_mode_out, 1'b0} :
                 ri == REG_STATUS ? {30'd0, done, busy} :
                 ri == REG_TIMING ? {8'd0, SCK_CS_out, CS_SCK_out, IFG_out} :
                 ri == REG_TXDATA ? mosi_data_out :
                 ri == REG_RXDATA ? rxdata : 32'd0;
    end
    always_ff @(posedge GCLK or negedge RST) begin
        if (!RST) begin
            en            <= 1'b0;
            busy_q        <= 1'b0;
            pending       <= 1'b0;
            done          <= 1'b0;
            start_out     <= 1'b0;
            spi_mode_out  <= '0;
            sck_speed_out <= '0;
            word_len_out  <= '0;
            IFG_out       <= '0;
            CS_SCK_out    <= '0;
            SCK_CS_out    <= '0;
            mosi_data_out <= '0;
            rxdata        <= '0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= 2'b00;
        end else begin
            en        <= 1'b1;
            busy_q    <= busy_in;
            start_out <= start;
            pending   <= start | (pending & ~rise);
            done      <= fall | (done & ~done_clr);
            if (fall) rxdata <= miso_data_in;
            if (wr_en && wi == REG_CTRL && wr_strb[0]) begin
                spi_mode_out  <= wr_data[CTRL_MODE+:2];
                sck_speed_out <= wr_data[CTRL_SPEED+:2];
                word_len_out  <= wr_data[CTRL_WLEN+:2];
            end
            if (wr_en && wi == REG_TIMING) begin
                if (wr_strb[TIM_IFG/8])    IFG_out    <= wr_data[TIM_IFG+:8];
                if (wr_strb[TIM_CS_SCK/8]) CS_SCK_out <= wr_data[TIM_CS_SCK+:8];
                if (wr_strb[TIM_SCK_CS/8]) SCK_CS_out <= wr_data[TIM_SCK_CS+:8];
            end
            for (int b = 0; b < 4; b++)
                if (wr_en && wi == REG_TXDATA && wr_strb[b]) mosi_data_out[8*b+:8] <= wr_data[8*b+:8];
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_val;
                S_AXI_RRESP  <= ri > REG_RXDATA ? RESP_SLVERR : RESP_OKAY;
            end else if (S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi_spi_csr.sv
// tb_axi_spi_csr: directed AXI4-Lite transactions against axi_spi_csr with hand-computed expectations.
module tb_axi_spi_csr;
    logic GCLK = 1'b0, RST = 1'b0;
    logic [4:0] S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
    logic S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_BREADY = 0, S_AXI_ARVALID = 0, S_AXI_RREADY = 0;
    logic [31:0] S_AXI_WDATA = '0, miso_data_in = '0;
    logic [3:0] S_AXI_WSTRB = '0;
    logic busy_in = 1'b0;
    logic S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, start_out;
    logic [1:0] S_AXI_BRESP, S_AXI_RRESP, spi_mode_out, sck_speed_out, word_len_out;
    logic [31:0] S_AXI_RDATA, mosi_data_out;
    logic [7:0] IFG_out, CS_SCK_out, SCK_CS_out;
    int n_cmp = 0, n_err = 0, start_cnt = 0;
    logic [31:0] rd;
    logic [1:0] rsp;

    axi_spi_csr #(.ADDR_W(5)) dut (
        .GCLK(GCLK), .RST(RST),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY), .start_out(start_out),
        .spi_mode_out(spi_mode_out), .sck_speed_out(sck_speed_out), .word_len_out(word_len_out),
        .IFG_out(IFG_out), .CS_SCK_out(CS_SCK_out), .SCK_CS_out(SCK_CS_out),
        .mosi_data_out(mosi_data_out), .busy_in(busy_in), .miso_data_in(miso_data_in)
    );

    always #5 GCLK = ~GCLK;
    always @(negedge GCLK) if (start_out) start_cnt <= start_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge GCLK);
        #1;
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r);
        logic aw_go, w_go;
        S_AXI_AWADDR = a; S_AXI_AWVALID = 1; S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1;
        for (int i = 0; i < 20 && (S_AXI_AWVALID || S_AXI_WVALID); i++) begin
            aw_go = S_AXI_AWVALID && S_AXI_AWREADY;
            w_go  = S_AXI_WVALID && S_AXI_WREADY;
            tick();
            if (aw_go) S_AXI_AWVALID = 0;
            if (w_go) S_AXI_WVALID = 0;
        end
        for (int i = 0; i < 20 && !S_AXI_BVALID; i++) tick();
        check("bvalid_seen", {31'd0, S_AXI_BVALID}, 32'd1);
        r = S_AXI_BRESP;
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 1;
        tick();
        S_AXI_BREADY = 0;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
        logic go;
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1;
        for (int i = 0; i < 20 && S_AXI_ARVALID; i++) begin
            go = S_AXI_ARREADY;
            tick();
            if (go) S_AXI_ARVALID = 0;
        end
        for (int i = 0; i < 20 && !S_AXI_RVALID; i++) tick();
        check("rvalid_seen", {31'd0, S_AXI_RVALID}, 32'd1);
        d = S_AXI_RDATA; r = S_AXI_RRESP;
        S_AXI_ARVALID = 0; S_AXI_RREADY = 1;
        tick();
        S_AXI_RREADY = 0;
    endtask

    initial begin
        #12;
        check("rst_readies", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd0);
        check("rst_valids", {29'd0, S_AXI_BVALID, S_AXI_RVALID, start_out}, 32'd0);
        check("rst_cfg", {26'd0, spi_mode_out, sck_speed_out, word_len_out}, 32'd0);
        @(posedge GCLK); #1 RST = 1;
        check("rdy_before_edge", {31'd0, S_AXI_AWREADY}, 32'd0);
        tick();
        check("rdy_after_edge", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd7);

        // W leads AW by three cycles
        S_AXI_WDATA = 32'h0003_0201; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
        tick();
        S_AXI_WVALID = 0;
        tick(); tick();
        check("wready_full", {31'd0, S_AXI_WREADY}, 32'd0);
        S_AXI_AWADDR = 5'h08; S_AXI_AWVALID = 1;
        tick();
        S_AXI_AWVALID = 0;
        check("tim_bvalid_early", {31'd0, S_AXI_BVALID}, 32'd0);
        tick();
        check("tim_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
        check("tim_bresp", {30'd0, S_AXI_BRESP}, 32'd0);
        check("tim_fields", {8'd0, SCK_CS_out, CS_SCK_out, IFG_out}, 32'h0003_0201);
        S_AXI_BREADY = 1;
        tick();
        S_AXI_BREADY = 0;
        check("tim_bvalid_drop", {31'd0, S_AXI_BVALID}, 32'd0);

        axi_write(5'h0C, 32'h1122_3344, 4'b0101, rsp);
        check("tx_strb_resp", {30'd0, rsp}, 32'd0);
        check("tx_strb_data", mosi_data_out, 32'h0022_0044);

        axi_write(5'h00, 32'h0000_002B, 4'hF, rsp);
        check("ctrl_resp", {30'd0, rsp}, 32'd0);
        check("ctrl_fields", {26'd0, spi_mode_out, sck_speed_out, word_len_out}, 32'b01_01_01);
        check("ctrl_start_cnt", start_cnt, 1);
        axi_read(5'h00, rd, rsp);
        check("ctrl_read", rd, 32'h0000_002A);
        axi_read(5'h04, rd, rsp);
        check("status_pending", rd, 32'h1);

        busy_in = 1;
        tick(); tick();
        axi_read(5'h04, rd, rsp);
        check("status_busy", rd, 32'h1);
        axi_write(5'h0C, 32'hDEAD_BEEF, 4'hF, rsp);
        check("tx_lock_resp", {30'd0, rsp}, 32'd2);
        check("tx_lock_data", mosi_data_out, 32'h0022_0044);
        axi_write(5'h00, 32'h0000_0001, 4'hF, rsp);
        check("ctrl_lock_resp", {30'd0, rsp}, 32'd2);
        check("ctrl_lock_mode", {30'd0, spi_mode_out}, 32'd1);
        check("ctrl_lock_start", start_cnt, 1);

        miso_data_in = 32'h1234_5678; busy_in = 0;
        tick(); tick();
        miso_data_in = 32'hFFFF_FFFF;
        axi_read(5'h10, rd, rsp);
        check("rx_data", rd, 32'h1234_5678);
        check("rx_resp", {30'd0, rsp}, 32'd0);
        axi_read(5'h04, rd, rsp);
        check("status_done", rd, 32'h2);
        axi_write(5'h04, 32'h2, 4'h1, rsp);
        check("w1c_resp", {30'd0, rsp}, 32'd0);
        axi_read(5'h04, rd, rsp);
        check("status_clear", rd, 32'h0);
        axi_write(5'h1C, 32'h5, 4'hF, rsp);
        check("bad_wr_resp", {30'd0, rsp}, 32'd2);

        // Unmapped read held without RREADY
        S_AXI_ARADDR = 5'h14; S_AXI_ARVALID = 1;
        tick();
        S_AXI_ARVALID = 0;
        for (int i = 0; i < 5; i++) begin
            check("hold_data", S_AXI_RDATA, 32'd0);
            check("hold_ctl", {28'd0, S_AXI_RVALID, S_AXI_ARREADY, S_AXI_RRESP}, 32'b1010);
            tick();
        end
        S_AXI_RREADY = 1;
        tick();
        S_AXI_RREADY = 0;
        check("hold_release", {31'd0, S_AXI_RVALID}, 32'd0);

        // Reset while a write response is outstanding
        S_AXI_AWADDR = 5'h00; S_AXI_WDATA = 32'h0000_007E; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
        tick();
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        tick();
        check("pre_rst_state", {29'd0, S_AXI_BVALID, spi_mode_out}, 32'b111);
        #2 RST = 0;
        #1;
        check("rst_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);
        check("rst_cfg_mid", {26'd0, spi_mode_out, sck_speed_out, word_len_out}, 32'd0);
        check("rst_regs_mid", {IFG_out, CS_SCK_out, SCK_CS_out, 8'd0} | mosi_data_out, 32'd0);
        @(posedge GCLK); #1 RST = 1;
        tick();
        axi_read(5'h00, rd, rsp);
        check("post_rst_ctrl", rd, 32'd0);
        check("post_rst_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
